ped_request_ctrl: RTL



---
 rtl/ped_request_ctrl_if.sv | 20 ++
 rtl/ped_request_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ped_request_ctrl_if.sv
// Pedestrian request bundle between the button front end and its environment:
// button, light state/countdown in; crossing request, WALK lamp and grant pulse out.
interface ped_request_ctrl_if;
   logic       btn_raw;
   logic [2:0] led;
   logic [7:0] clock;
   logic       pass_request;
   logic       walk;
   logic       served;

   modport master (
      output btn_raw, led, clock,
      input  pass_request, walk, served
   );

   modport slave (
      input  btn_raw, led, clock,
      output pass_request, walk, served
   );
endinterface

// File: rtl/ped_request_ctrl.sv
// Pedestrian push-button front end: synchronise, debounce, latch a crossing request,
// drive WALK during red and hold off new requests for a cooldown. Option: WALK_BLINK_EN.
module ped_request_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int COOLDOWN_CYCLES = 20,
   parameter int WARN_CYCLES     = 5
) (
   input logic             clk,
   input logic             rst_n,
   ped_request_ctrl_if.slave bus
);
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
   localparam int CD_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PENDING  = 2'd1,
      SERVING  = 2'd2,
      COOLDOWN = 2'd3
   } state_t;

   state_t          state_r, next_state_s;
   logic            sync1_r, btn_s_r;
   logic            btn_db_r, btn_db_q_r;
   logic [DB_W-1:0] db_cnt_r;
   logic [CD_W-1:0] cd_cnt_r;
   logic            deferred_r;
   logic            red_q_r;
   logic            pass_request_r, walk_r, served_r;
   logic            pass_next_s, walk_next_s, served_next_s;
   logic            press_s, red_s, red_entry_s;

   // Only the exact one-hot red code counts as red
   assign red_s       = (bus.led == 3'b001);
   assign red_entry_s = red_s & ~red_q_r;
   assign press_s     = btn_db_r & ~btn_db_q_r;

   // Two-flop synchroniser for the asynchronous button
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 1'b0;
         btn_s_r <= 1'b0;
      end else begin
         sync1_r <= bus.btn_raw;
         btn_s_r <= sync1_r;
      end
   end

   // Debounce: level only moves after DEBOUNCE_CYCLES consecutive differing samples
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_cnt_r   <= {DB_W{1'b0}};
         btn_db_r   <= 1'b0;
         btn_db_q_r <= 1'b0;
         red_q_r    <= 1'b0;
      end else begin
         btn_db_q_r <= btn_db_r;
         red_q_r    <= red_s;
         if (btn_s_r == btn_db_r) begin
            db_cnt_r <= {DB_W{1'b0}};
         end else if (db_cnt_r == DB_LAST) begin
            btn_db_r <= btn_s_r;
            db_cnt_r <= {DB_W{1'b0}};
         end else begin
            db_cnt_r <= db_cnt_r + 1'b1;
         end
      end
   end

   // Cooldown counter and deferred-press flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cd_cnt_r   <= {CD_W{1'b0}};
         deferred_r <= 1'b0;
      end else begin
         if (state_r == SERVING && !red_s) begin
            cd_cnt_r <= CD_LOAD;
         end else if (state_r == COOLDOWN && cd_cnt_r != {CD_W{1'b0}}) begin
            cd_cnt_r <= cd_cnt_r - 1'b1;
         end else begin
            cd_cnt_r <= cd_cnt_r;
         end
         if (state_r != COOLDOWN || cd_cnt_r == {CD_W{1'b0}}) begin
            deferred_r <= 1'b0;
         end else if (press_s) begin
            deferred_r <= 1'b1;
         end else begin
            deferred_r <= deferred_r;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (press_s) next_state_s = PENDING;
            else         next_state_s = IDLE;
         end
         PENDING: begin
            if (red_entry_s) next_state_s = SERVING;
            else             next_state_s = PENDING;
         end
         SERVING: begin
            if (!red_s) next_state_s = COOLDOWN;
            else        next_state_s = SERVING;
         end
         COOLDOWN: begin
            // A press landing on the expiry cycle still counts as deferred
            if (cd_cnt_r == {CD_W{1'b0}}) begin
               if (deferred_r || press_s) next_state_s = PENDING;
               else                       next_state_s = IDLE;
            end else begin
               next_state_s = COOLDOWN;
            end
         end
         default: next_state_s = IDLE;
      endcase
   end

   // Output decode from the upcoming state so the outputs leave a register
   always_comb begin
      pass_next_s   = 1'b0;
      walk_next_s   = 1'b0;
      served_next_s = 1'b0;
      case (next_state_s)
         PENDING: pass_next_s = 1'b1;
         SERVING: walk_next_s = 1'b1;
         default: begin
            pass_next_s = 1'b0;
            walk_next_s = 1'b0;
         end
      endcase
      if (state_r == PENDING && red_entry_s) served_next_s = 1'b1;
      else                                   served_next_s = 1'b0;
   end

   // Output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass_request_r <= 1'b0;
         walk_r         <= 1'b0;
         served_r       <= 1'b0;
      end else begin
         pass_request_r <= pass_next_s;
         walk_r         <= walk_next_s;
         served_r       <= served_next_s;
      end
   end

   assign bus.pass_request = pass_request_r;
   assign bus.served       = served_r;

`ifdef WALK_BLINK_EN
   // Flash WALK with the controller countdown during the final red counts
   assign bus.walk = walk_r & ((bus.clock >= 8'(WARN_CYCLES)) | bus.clock[0]);
`else
   logic unused_clock_s;
   assign unused_clock_s = ^{bus.clock, 8'(WARN_CYCLES)};
   assign bus.walk       = walk_r;
`endif

endmodule
